stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of stack entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-005 SHALL have port push  input  1  write din onto the stack this cycle.
REQ-006 SHALL have port pop  input  1  remove the top entry and capture it on dout.
REQ-007 SHALL have port tos  input  1  capture the top entry on dout without removing it.
REQ-008 SHALL have port din  input  WIDTH  data to push, the value written back from the datapath (memory or ALU result).
REQ-009 SHALL have port dout  output  WIDTH  registered top-of-stack capture, consumed by the datapath A/B operand registers.
REQ-010 SHALL have port count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-011 SHALL have ports empty and full  output  1 each  count==0 and count==DEPTH respectively, combinational from count.
REQ-012 SHALL have port err_clr  input  1  clear the sticky error flags.
REQ-013 SHALL have ports ovf and unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-014 SHALL hold entries in a DEPTH x WIDTH register array with stack pointer sp equal to count; entry index sp-1 is the top.
REQ-015 SHALL, on push only with !full: write din to entry[sp] and increment count, in the same edge.
REQ-016 SHALL, on pop only with !empty: load dout with entry[sp-1] and decrement count; dout valid the cycle after the pop edge (latency 1).
REQ-017 SHALL, on tos only with !empty: load dout with entry[sp-1] and leave count unchanged; latency 1.
REQ-018 SHALL, on push and pop together with !empty: load dout with the old top, overwrite entry[sp-1] with din, and leave count unchanged (replace top).
REQ-019 SHALL, on push and pop together with empty: treat the request as push only and set unf.
REQ-020 SHALL treat tos asserted together with pop as pop; tos together with push only as push followed by no capture.
REQ-021 SHALL, on push only with full: ignore the write, leave count and entries unchanged, and set ovf.
REQ-022 SHALL, on pop or tos with empty: leave dout and count unchanged and set unf.
REQ-023 SHALL hold dout unchanged in every cycle without a successful pop, tos, or replace operation.
REQ-024 SHALL keep ovf and unf set until err_clr; err_clr in the same cycle as a new error leaves the flag set (set wins).
REQ-025 SHALL never wrap sp: count saturates at DEPTH and at 0.

Reset
REQ-026 SHALL, when rst=0, asynchronously force count=0, dout=0, ovf=0, unf=0; hence empty=1 and full=0.
REQ-027 SHALL leave array contents undefined after reset; a read before any push is an underflow per REQ-022.
REQ-028 SHALL abort any operation coinciding with reset assertion; the first operation is honoured on the first rising edge after rst returns to 1.

Configuration
REQ-029 SHALL honour macro STACK_ERR_EN: when defined, ovf and unf behave per REQ-021, REQ-022, and REQ-024.
REQ-030 SHALL, without STACK_ERR_EN, tie ovf and unf to 0 and ignore err_clr; overflow and underflow requests are still ignored as specified.

Verification
REQ-031 SHALL cover: after reset, push 0x11, 0x22, 0x33, then pop x3 -> dout 0x33, 0x22, 0x11 on successive cycles; count 3->0; empty=1.
REQ-032 SHALL cover: DEPTH=8, push 9 values 0x01..0x09 -> count=8, full=1, ovf=1 (STACK_ERR_EN); pop -> dout=0x08.
REQ-033 SHALL cover: with empty=1, pop -> dout unchanged, count=0, unf=1; err_clr -> unf=0 next cycle.
REQ-034 SHALL cover: stack {0x05, 0x07}, tos -> dout=0x07, count=2; push 0x09 with pop -> dout=0x07, count=2; pop -> dout=0x09.
REQ-035 SHALL cover: count=4, assert rst=0 mid-cycle -> count=0, dout=0, flags=0 before the next clk edge; a push after release -> count=1.
REQ-036 SHALL cover: build without STACK_ERR_EN, pop on empty and push on full -> ovf=unf=0 throughout; count stays saturated.

Source files
------------

// File: rtl/stack_unit.sv
// LIFO stack of DEPTH x WIDTH entries with push/pop/tos/replace and sticky ovf/unf flags (macro STACK_ERR_EN).
// Latency: pop/tos/replace capture the top entry on dout one cycle after the edge; count updates on the same edge.
// Backpressure: none; push on full and pop/tos on empty are dropped and flagged, count saturates at DEPTH and 0.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   tos,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    input  logic                   err_clr,
    output logic                   ovf,
    output logic                   unf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_set, unf_set;
    logic [AW-1:0]    top_idx, wr_idx;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign top_idx = AW'(count_q - CW'(1));
    assign wr_idx  = count_q[AW-1:0];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        dout_d  = dout_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        // pop dominates tos; push+pop on a non-empty stack replaces the top in place
        if (push && pop) begin
            if (!empty) begin
                dout_d         = mem_q[top_idx];
                mem_d[top_idx] = din;
            end else begin
                mem_d[wr_idx] = din;
                count_d       = count_q + CW'(1);
                unf_set       = 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                dout_d  = mem_q[top_idx];
                count_d = count_q - CW'(1);
            end else begin
                unf_set = 1'b1;
            end
        end else if (push) begin
            if (!full) begin
                mem_d[wr_idx] = din;
                count_d       = count_q + CW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (tos) begin
            if (!empty) begin
                dout_d = mem_q[top_idx];
            end else begin
                unf_set = 1'b1;
            end
        end
    end

    // Entry storage carries no reset; reads are gated by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    assign count = count_q;
    assign dout  = dout_q;

`ifdef STACK_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~err_clr);
        unf_d = unf_set | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    logic unused_err;
    assign unused_err = err_clr ^ ovf_set ^ unf_set;
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed vector table, hand-written full/reset sequences, then random traffic against a queue model.
module tb_stack_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
`ifdef STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic [3:0]       count;
    logic             empty, full, ovf, unf;

    int n_tests = 0;
    int n_fail  = 0;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
        .dout(dout), .count(count), .empty(empty), .full(full),
        .err_clr(err_clr), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push, pop, tos, clr;
        logic [7:0] din;
        logic [7:0] e_dout;
        int         e_count;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic o, input logic t, input logic c, input logic [7:0] d);
        push = p; pop = o; tos = t; err_clr = c; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic [7:0] e_dout, input int e_count,
                             input logic e_ovf, input logic e_unf);
        chk({nm, ".dout"},  32'(dout),  32'(e_dout));
        chk({nm, ".count"}, 32'(count), 32'(e_count));
        chk({nm, ".empty"}, 32'(empty), 32'(e_count == 0));
        chk({nm, ".full"},  32'(full),  32'(e_count == DEPTH));
        chk({nm, ".ovf"},   32'(ovf),   32'(e_ovf & ERR_EN));
        chk({nm, ".unf"},   32'(unf),   32'(e_unf & ERR_EN));
    endtask

    // Reference model: a plain queue whose back is the top of stack.
    int         mq[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_unf;

    task automatic model_step(input logic p, input logic o, input logic t, input logic c, input logic [7:0] d);
        logic so, su;
        so = 1'b0; su = 1'b0;
        if (p && o) begin
            if (mq.size() > 0) begin
                m_dout = 8'(mq[$]);
                mq[$]  = int'(d);
            end else begin
                mq.push_back(int'(d));
                su = 1'b1;
            end
        end else if (o) begin
            if (mq.size() > 0) m_dout = 8'(mq.pop_back());
            else su = 1'b1;
        end else if (p) begin
            if (mq.size() < DEPTH) mq.push_back(int'(d));
            else so = 1'b1;
        end else if (t) begin
            if (mq.size() > 0) m_dout = 8'(mq[$]);
            else su = 1'b1;
        end
        m_ovf = so | (m_ovf & ~c);
        m_unf = su | (m_unf & ~c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           push pop tos clr din    dout  cnt ovf unf
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00, 1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 2, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00, 3, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h33, 2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h22, 1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h11, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 8'h11, 2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 2, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h09, 8'h07, 2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h09, 1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05, 0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h05, 1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hAA, 0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hAA, 0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hAA, 0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk_state("reset", 8'h00, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].push, tbl[i].pop, tbl[i].tos, tbl[i].clr, tbl[i].din);
            chk_state($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_count, tbl[i].e_ovf, tbl[i].e_unf);
        end

        // Fill past full: the ninth push is dropped
        for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
        chk_state("fill9", 8'hAA, 8, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h5C);
        chk_state("replace_full", 8'h08, 8, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_state("pop_after_full", 8'h5C, 7, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk_state("clr_ovf", 8'h07, 6, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_state("count4", 8'h05, 4, 1'b0, 1'b0);

        // Mid-cycle asynchronous reset with a push held active
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_state("async_rst", 8'h00, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_state("rst_hold", 8'h00, 0, 1'b0, 1'b0);
        push = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        chk_state("push_after_rst", 8'h00, 1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk_state("tos_after_rst", 8'h3C, 1, 1'b0, 1'b0);

        // Random traffic against the queue model
        mq.delete();
        mq.push_back(32'h3C);
        m_dout = 8'h3C; m_ovf = 1'b0; m_unf = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic p, o, t, c;
            logic [7:0] d;
            int bias;
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(0, 99) < bias);
            o = ($urandom_range(0, 99) < (100 - bias));
            t = ($urandom_range(0, 99) < 25);
            c = ($urandom_range(0, 99) < 8);
            d = 8'($urandom_range(0, 255));
            model_step(p, o, t, c, d);
            cyc(p, o, t, c, d);
            chk_state($sformatf("rnd%0d", i), m_dout, mq.size(), m_ovf, m_unf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
